// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg
// Shared definitions for the March C- RAM self-test: FSM state encoding,
// element count and the per-element behaviour table.
//
// Element table: bit i of each vector describes element Mi.
//   M0: up,   w0
//   M1: up,   r0 w1
//   M2: up,   r1 w0
//   M3: down, r0 w1
//   M4: down, r1 w0
//   M5: down, r0
// The vectors are 8 bits wide so that indexing with "element + 1" from the
// final element stays inside the vector (the extra bits are never acted on).
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int         NUM_ELEMENTS = 6;
    localparam logic [2:0] LAST_ELEMENT = 3'(NUM_ELEMENTS - 1);

    // Address direction: 1 = N-1 down to 0.
    localparam logic [7:0] EL_DOWN   = 8'b0011_1000;
    // Element starts each address with a read.
    localparam logic [7:0] EL_READ   = 8'b0011_1110;
    // Expected read pattern: 1 = all ones.
    localparam logic [7:0] EL_RD_ONE = 8'b0001_0100;
    // Element writes each address.
    localparam logic [7:0] EL_WRITE  = 8'b0001_1111;
    // Write pattern: 1 = all ones.
    localparam logic [7:0] EL_WR_ONE = 8'b0000_1010;

endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if
// Single-port synchronous RAM bus between the BIST engine and the RAM.
//   mem_addr      address presented to the RAM
//   mem_din       write data
//   mem_write_en  write strobe
//   mem_dout      read data, valid one cycle after the address (registered)
// Modports: master = BIST side, slave = RAM side.
interface ram_bist_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) ();

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_din;
    logic                  mem_write_en;
    logic [WIDTH-1:0]      mem_dout;

    modport master (
        output mem_addr,
        output mem_din,
        output mem_write_en,
        input  mem_dout
    );

    modport slave (
        input  mem_addr,
        input  mem_din,
        input  mem_write_en,
        output mem_dout
    );

endinterface

// File: rtl/ram_bist_addr_gen.sv
// bist_addr_gen
// Up/down address counter for the March sequence.
//   clk, rst   clock and synchronous active-high reset
//   load       load the start address of an element
//   load_down  direction of the element being loaded (start at N-1 if set, else 0)
//   step       move to the next address in direction 'down'
//   down       direction of the element currently running
//   addr       current address
//   last       current address is the terminal address for direction 'down'
module bist_addr_gen #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    input  logic                  down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end
    end

    // Terminal address is compared directly so that an element never relies
    // on the counter wrapping around.
    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_bist.sv
// ram_bist
// March C- built-in self-test initiator for a single-port synchronous RAM.
//   clk, rst    clock and synchronous active-high reset
//   start       begin a run (only honoured while idle)
//   mem         RAM bus (master side)
//   busy        high while a run is in progress
//   done        one-cycle pulse at the end of a run
//   pass        result of the last completed run
//   fail_addr   address of the first mismatch (0 on pass)
//   fail_data   data read at fail_addr (0 on pass)
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    ram_bist_if.master            mem,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0]      fail_data
);

    state_t                state;
    logic [2:0]            element;
    logic [2:0]            next_element;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;
    logic [WIDTH-1:0]      expected;
    logic [WIDTH-1:0]      write_data;
    logic                  mismatch;
    logic                  advance;
    logic                  gen_load;
    logic                  gen_load_down;
    logic                  gen_step;

    // Control decode. A mismatch only counts during CHECK, where mem_dout
    // carries the data for the address presented in the preceding READ.
    // The counter reloads when an element finishes at its terminal address,
    // unless that was the final element.
    always_comb begin
        next_element  = element + 3'd1;
        expected      = EL_RD_ONE[element] ? '1 : '0;
        write_data    = EL_WR_ONE[element] ? '1 : '0;
        mismatch      = (state == ST_CHECK) && (mem.mem_dout != expected);
        advance       = (state == ST_WRITE) || ((state == ST_CHECK) && !mismatch);
        gen_load      = ((state == ST_IDLE) && start) ||
                        (advance && last && (element != LAST_ELEMENT));
        gen_load_down = (state == ST_IDLE) ? EL_DOWN[0] : EL_DOWN[next_element];
        gen_step      = advance && !last;
    end

    bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (gen_load),
        .load_down (gen_load_down),
        .step      (gen_step),
        .down      (EL_DOWN[element]),
        .addr      (addr),
        .last      (last)
    );

    // RAM bus decode. In a read+write element the new pattern is written in
    // the CHECK cycle itself, but only if the read matched.
    always_comb begin
        mem.mem_addr     = '0;
        mem.mem_din      = '0;
        mem.mem_write_en = 1'b0;
        case (state)
            ST_WRITE: begin
                mem.mem_addr     = addr;
                mem.mem_din      = write_data;
                mem.mem_write_en = 1'b1;
            end
            ST_READ: begin
                mem.mem_addr = addr;
            end
            ST_CHECK: begin
                mem.mem_addr     = addr;
                mem.mem_din      = EL_WRITE[element] ? write_data : '0;
                mem.mem_write_en = EL_WRITE[element] && !mismatch;
            end
            default: begin
            end
        endcase
    end

    // Main sequencer. WRITE and CHECK share the "advance" path: step to the
    // next address, or at the terminal address move to the next element
    // (whose first state depends on whether it reads), or finish after M5.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            element   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_WRITE;
                        element   <= '0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
                    end
                end
                ST_WRITE, ST_CHECK: begin
                    if (mismatch) begin
                        fail_addr <= addr;
                        fail_data <= mem.mem_dout;
                        pass      <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else if (last) begin
                        if (element == LAST_ELEMENT) begin
                            pass  <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            element <= next_element;
                            state   <= EL_READ[next_element] ? ST_READ : ST_WRITE;
                        end
                    end else begin
                        state <= EL_READ[element] ? ST_READ : ST_WRITE;
                    end
                end
                ST_READ: begin
                    state <= ST_CHECK;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist
// Self-checking bench for ram_bist with default parameters (N = 256).
// A behavioural RAM with injectable faults (stuck-at-1, stuck-at-0, coupling)
// sits on the bus. Before each run a reference model walks the March C-
// element table over a copy of the RAM contents, producing the expected
// per-cycle bus access sequence and the expected pass/fail result.
module tb_ram_bist;

    localparam int WIDTH      = 16;
    localparam int ADDR_WIDTH = 8;
    localparam int N          = 1 << ADDR_WIDTH;
    localparam int RUN_CYCLES = 11 * N;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [WIDTH-1:0]      din;
    } access_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [WIDTH-1:0]      fail_data;

    int assert_count = 0;
    int fail_count   = 0;

    logic [WIDTH-1:0]      ram [N];
    logic [WIDTH-1:0]      mdl [N];
    int                    fault_kind;
    logic [ADDR_WIDTH-1:0] fault_addr;
    logic [ADDR_WIDTH-1:0] agg_addr;
    logic [WIDTH-1:0]      fault_mask;

    access_t               exp_q [$];
    logic                  exp_pass;
    logic [ADDR_WIDTH-1:0] exp_fail_addr;
    logic [WIDTH-1:0]      exp_fail_data;

    // March C- as a table: direction, read pattern (-1 none), write pattern (-1 none)
    int el_down [6] = '{0, 0, 0, 1, 1, 1};
    int el_rd   [6] = '{-1, 0, 1, 0, 1, 0};
    int el_wr   [6] = '{0, 1, 0, 1, 0, -1};

    ram_bist_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    ram_bist #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem       (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pattern(input int p);
        return (p != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    endfunction

    // Stuck-at faults act on the read path of one cell.
    function automatic logic [WIDTH-1:0] read_fault(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        if (fault_kind == 1 && a == fault_addr) r = r | fault_mask;
        if (fault_kind == 2 && a == fault_addr) r = r & ~fault_mask;
        return r;
    endfunction

    // Behavioural RAM: registered read, coupling fault flips the victim on
    // every write to the aggressor. Contents are scrambled while in reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) ram[i] <= WIDTH'($urandom);
        end else begin
            bus.mem_dout <= read_fault(bus.mem_addr, ram[bus.mem_addr]);
            if (bus.mem_write_en) begin
                ram[bus.mem_addr] <= bus.mem_din;
                if (fault_kind == 3 && bus.mem_addr == agg_addr)
                    ram[fault_addr] <= ram[fault_addr] ^ fault_mask;
            end
        end
    end

    function automatic access_t make_access(input logic [ADDR_WIDTH-1:0] a,
                                            input logic we, input logic [WIDTH-1:0] d);
        access_t t;
        t.addr = a;
        t.we   = we;
        t.din  = d;
        return t;
    endfunction

    task automatic model_write(input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] w);
        mdl[a] = w;
        if (fault_kind == 3 && a == agg_addr) mdl[fault_addr] = mdl[fault_addr] ^ fault_mask;
    endtask

    // Walk the element table; each read costs a READ and a CHECK cycle,
    // a write-only step costs one cycle. Stop at the first bad read.
    task automatic build_model();
        logic                  ok;
        logic [ADDR_WIDTH-1:0] a;
        logic [WIDTH-1:0]      v;
        logic [WIDTH-1:0]      w;
        exp_q.delete();
        ok            = 1'b1;
        exp_fail_addr = '0;
        exp_fail_data = '0;
        for (int i = 0; i < N; i++) mdl[i] = ram[i];
        for (int e = 0; e < 6 && ok; e++) begin
            for (int j = 0; j < N && ok; j++) begin
                a = (el_down[e] != 0) ? ADDR_WIDTH'(N - 1 - j) : ADDR_WIDTH'(j);
                if (el_rd[e] >= 0) begin
                    exp_q.push_back(make_access(a, 1'b0, '0));
                    v = read_fault(a, mdl[a]);
                    if (v !== pattern(el_rd[e])) begin
                        exp_q.push_back(make_access(a, 1'b0, '0));
                        ok            = 1'b0;
                        exp_fail_addr = a;
                        exp_fail_data = v;
                    end else if (el_wr[e] >= 0) begin
                        w = pattern(el_wr[e]);
                        exp_q.push_back(make_access(a, 1'b1, w));
                        model_write(a, w);
                    end else begin
                        exp_q.push_back(make_access(a, 1'b0, '0));
                    end
                end else begin
                    w = pattern(el_wr[e]);
                    exp_q.push_back(make_access(a, 1'b1, w));
                    model_write(a, w);
                end
            end
        end
        exp_pass = ok;
    endtask

    function automatic bit bus_matches(input access_t x);
        return (bus.mem_addr === x.addr) && (bus.mem_write_en === x.we) &&
               (!x.we || (bus.mem_din === x.din));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, " busy"},         32'(busy),             32'd0);
        checkOutput({tag, " done"},         32'(done),             32'd0);
        checkOutput({tag, " pass"},         32'(pass),             32'd0);
        checkOutput({tag, " fail_addr"},    32'(fail_addr),        32'd0);
        checkOutput({tag, " fail_data"},    32'(fail_data),        32'd0);
        checkOutput({tag, " mem_write_en"}, 32'(bus.mem_write_en), 32'd0);
        checkOutput({tag, " mem_addr"},     32'(bus.mem_addr),     32'd0);
        checkOutput({tag, " mem_din"},      32'(bus.mem_din),      32'd0);
    endtask

    // One run: start, follow it cycle by cycle against the model, then check
    // the result. pulse_at = cycle of an extra start pulse (0 = none),
    // rst_at = cycle at which reset is forced (0 = none), hold = keep start high.
    task automatic applyStimulus(input string tag, input int pulse_at,
                                 input int rst_at, input bit hold);
        int   c;
        int   done_cycle;
        int   seq_err;
        int   len;
        logic saw_done;
        build_model();
        len = exp_q.size();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start      = hold;
        c          = 1;
        done_cycle = 0;
        seq_err    = 0;
        saw_done   = 1'b0;
        while (!saw_done && c <= RUN_CYCLES + 8) begin
            if (c <= len) begin
                if (!(busy === 1'b1 && done === 1'b0 && bus_matches(exp_q[c-1]))) seq_err++;
            end
            if (busy === 1'b1 && done === 1'b1) seq_err++;
            if (done === 1'b1) begin
                saw_done   = 1'b1;
                done_cycle = c;
            end
            if (c == rst_at) begin
                checkOutput({tag, " access_errors"}, 32'(seq_err), 32'd0);
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                check_reset_values({tag, " after_rst"});
                rst = 1'b0;
                return;
            end
            if (!saw_done) begin
                start = (c == pulse_at) ? 1'b1 : hold;
                @(negedge clk);
                c++;
            end
        end
        start = hold;
        checkOutput({tag, " done_cycle"},    32'(done_cycle),    32'(len + 1));
        checkOutput({tag, " access_errors"}, 32'(seq_err),       32'd0);
        checkOutput({tag, " pass"},          32'(pass),          32'(exp_pass));
        checkOutput({tag, " fail_addr"},     32'(fail_addr),     32'(exp_fail_addr));
        checkOutput({tag, " fail_data"},     32'(fail_data),     32'(exp_fail_data));
        if (exp_pass) checkOutput({tag, " run_length"}, 32'(done_cycle), 32'(RUN_CYCLES + 1));
        @(negedge clk);
        checkOutput({tag, " idle busy"},      32'(busy),             32'd0);
        checkOutput({tag, " idle done"},      32'(done),             32'd0);
        checkOutput({tag, " held pass"},      32'(pass),             32'(exp_pass));
        checkOutput({tag, " held fail_addr"}, 32'(fail_addr),        32'(exp_fail_addr));
        checkOutput({tag, " idle write_en"},  32'(bus.mem_write_en), 32'd0);
        checkOutput({tag, " idle addr"},      32'(bus.mem_addr),     32'd0);
        checkOutput({tag, " idle din"},       32'(bus.mem_din),      32'd0);
        if (hold) begin
            @(negedge clk);
            checkOutput({tag, " retrigger busy"},     32'(busy),             32'd1);
            checkOutput({tag, " retrigger write_en"}, 32'(bus.mem_write_en), 32'd1);
            checkOutput({tag, " retrigger addr"},     32'(bus.mem_addr),     32'd0);
            start = 1'b0;
            rst   = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        fault_kind = 0;
        fault_addr = '0;
        agg_addr   = '0;
        fault_mask = '0;
        repeat (3) @(negedge clk);
        check_reset_values("power_on");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus("clean", 0, 0, 1'b0);

        fault_kind = 1;
        fault_addr = ADDR_WIDTH'(5);
        fault_mask = WIDTH'(16'h0008);
        applyStimulus("stuck1", 0, 0, 1'b0);
        checkOutput("stuck1 plan fail_addr", 32'(fail_addr), 32'd5);
        checkOutput("stuck1 plan fail_data", 32'(fail_data), 32'h0008);
        checkOutput("stuck1 plan pass",      32'(pass),      32'd0);

        fault_kind = 3;
        agg_addr   = ADDR_WIDTH'(2);
        fault_addr = ADDR_WIDTH'(3);
        fault_mask = WIDTH'(16'h0001);
        applyStimulus("coupling", 0, 0, 1'b0);
        checkOutput("coupling plan fail_addr", 32'(fail_addr), 32'd3);
        checkOutput("coupling plan pass",      32'(pass),      32'd0);

        for (int k = 0; k < 4; k++) begin
            fault_kind = int'($urandom_range(1, 3));
            fault_addr = ADDR_WIDTH'($urandom);
            fault_mask = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            agg_addr   = fault_addr + ADDR_WIDTH'($urandom_range(1, N - 1));
            applyStimulus($sformatf("random%0d", k), 0, 0, 1'b0);
        end

        fault_kind = 0;
        applyStimulus("start_while_busy", int'($urandom_range(2, RUN_CYCLES - 2)), 0, 1'b0);
        applyStimulus("reset_mid_m3", 0, 5 * N + 1 + int'($urandom_range(0, 2 * N - 1)), 1'b0);
        applyStimulus("after_reset", 0, 0, 1'b0);
        applyStimulus("held_start", 0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test initiator for a single-port synchronous block RAM (BRAM) with `din`/`addr`/`write_en`/`dout` ports. On `start` it runs a March C- sequence over the whole address space, compares every read against the expected pattern, and reports pass/fail plus the first failing address and data. It sits between a board top level (start button, LEDs) and any BRAM instance on the iCEstick.

## Interface
- `WIDTH`, 16, RAM data width.
- `ADDR_WIDTH`, 8, RAM address width; depth N = 2**ADDR_WIDTH.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a test run; sampled only in IDLE.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_din`  out  WIDTH  RAM write data.
- `mem_write_en`  out  1  RAM write strobe.
- `mem_dout`  in  WIDTH  RAM read data, valid one cycle after the address is presented (registered read).
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  result of the last completed run; held until the next `start`.
- `fail_addr`  out  ADDR_WIDTH  address of the first mismatch; 0 on pass.
- `fail_data`  out  WIDTH  data read at `fail_addr`; 0 on pass.

## Operation
- Patterns: P0 = all zeros, P1 = all ones (WIDTH bits).
- Elements, in order:
  - M0: up, w0.
  - M1: up, r0 w1.
  - M2: up, r1 w0.
  - M3: down, r0 w1.
  - M4: down, r1 w0.
  - M5: down, r0.
- Up elements run addresses 0 .. N-1; down elements run N-1 .. 0. Address counter width is ADDR_WIDTH, and element end is detected on the terminal address, never on counter wrap.
- FSM states:
  - IDLE: `start` -> WRITE with element M0, addr 0, and clears `pass`, `fail_addr`, `fail_data`.
  - WRITE: `mem_write_en`=1, `mem_din`=element write pattern. Next address, or next element's first state at the terminal address.
  - READ: `mem_write_en`=0, address presented. -> CHECK.
  - CHECK: same address held. `mem_dout` is compared to the expected pattern.
    - Mismatch: latch `fail_addr`/`fail_data`, `pass`=0, -> DONE; no write this cycle.
    - Match in r+w elements: `mem_write_en`=1 with the new pattern in the same cycle, then advance.
    - Match in M5: advance only.
  - After M5 completes with no mismatch: `pass`=1, -> DONE.
  - DONE: `done`=1 for one cycle, -> IDLE.
- `mem_*` outputs are decoded from the state and counter registers. In IDLE/DONE: `mem_write_en`=0, `mem_addr`=0, `mem_din`=0.
- `start` while `busy` is ignored. `start` held high re-triggers a new run from IDLE after DONE.
- `rst` at any time, including mid-run, forces IDLE on the next edge. The test is abandoned and the RAM contents are undefined.
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_data`=0, `mem_write_en`=0, `mem_addr`=0, `mem_din`=0.

## Timing
- Cycle counts:
  - WRITE-only element: 1 cycle/address.
  - READ/CHECK elements: 2 cycles/address.
  - Full passing run: N + 4·2N + 2N = 11N cycles of `busy`.
- `start` sampled at edge k:
  - `busy`=1 and the first write (addr 0, P0) occur in cycle k+1.
  - The last CHECK (M5, addr 0) occurs in cycle k+11N.
  - `done`=1 and `busy`=0 in cycle k+11N+1.
- On a failure, `done` pulses the cycle after the failing CHECK.
- `pass`, `fail_addr` and `fail_data` are valid from the `done` cycle and stable until the next accepted `start` or `rst`.
- `busy` and `done` are never high together.

## Structure
- `ram_bist_defs.vh`, shared include:
  - state encodings;
  - element count (6);
  - per-element constants: direction, read-enable, expected pattern select, write-enable, write pattern select.
- One sub-module, `bist_addr_gen`: up/down address counter with load-to-start (0 or N-1) and a terminal-address flag.
- The RAM itself is external, instantiated alongside in the board top level.

## Test plan
- Fault-free RAM model (registered read), ADDR_WIDTH=3, start pulse at cycle 10 -> `busy` cycles 11..98, `done` at cycle 99, `pass`=1, `fail_addr`=0.
- Stuck-at-1 on bit 3 of addr 5, WIDTH=16 -> first mismatch in M1 read at addr 5, `fail_addr`=5, `fail_data`=16'h0008, `pass`=0; `done` the cycle after that CHECK.
- Coupling fault (write to addr 2 flips bit 0 of addr 3) -> failure detected with `fail_addr`=3, `pass`=0.
- `start` pulsed again while `busy` -> ignored; `done` timing unchanged at 11N+1 after the original start.
- `rst` asserted mid-M3 -> next cycle `busy`=0, `mem_write_en`=0, all outputs at reset values. A subsequent `start` runs to `pass`=1.
- Default parameters, fault-free model -> `done` exactly 2817 cycles after the start edge, `pass`=1; check all 2816 RAM accesses against the expected address/op sequence.
